// File: rtl/ramio_uart_fifo_pkg.sv
// Shared constants and types for the buffered memory-mapped UART.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ramio_uart_fifo_pkg;

  // Default bus addresses of the three UART registers
  localparam logic [31:0] DefAddrUartOut    = 32'hffff_fff8;
  localparam logic [31:0] DefAddrUartIn     = 32'hffff_fff4;
  localparam logic [31:0] DefAddrUartStatus = 32'hffff_ffdc;

  // Status word bit positions
  localparam int StatRxNotEmpty = 0;
  localparam int StatTxFull     = 1;
  localparam int StatOverrun    = 2;
  localparam int StatTxIdle     = 3;
  localparam int StatRxCountLsb = 8;
  localparam int StatTxCountLsb = 16;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_ARM  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ramio_uart_fifo_io_fifo.sv
// Small synchronous FIFO with combinational head, occupancy count and flags.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module io_fifo #(
  parameter int Width     = 8,
  parameter int DepthLog2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [Width-1:0]     data_i,
  output logic [Width-1:0]     data_o,
  output logic [DepthLog2:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int Depth = 2 ** DepthLog2;
  localparam logic [DepthLog2:0] DepthCount = (DepthLog2 + 1)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == DepthCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the coinciding push fills, so full+pop+push is legal
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset because count guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally modulo depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uartrx.sv
// 8N1 serial receiver sampling mid-bit; holds drdy_o until go_i is dropped.
// Latency: drdy_o rises in the middle of the stop bit plus two synchroniser cycles.
// Backpressure: none; a new frame overwrites data_o if the previous one was not acknowledged.
module uartrx #(
  parameter int ClockFrequencyHz = 20_250_000,
  parameter int BaudRate         = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       go_i,
  output logic [7:0] data_o,
  output logic       drdy_o
);

  localparam int Div = ClockFrequencyHz / BaudRate;
  localparam int CW  = $clog2(Div) + 1;
  localparam logic [CW-1:0] DivM1  = CW'(Div - 1);
  localparam logic [CW-1:0] HalfM1 = CW'(Div / 2 - 1);

  logic          s1_q, s2_q, prev_q, busy_q, drdy_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shreg_q, data_q;
  logic [CW-1:0] target;

  assign data_o = data_q;
  assign drdy_o = drdy_q;
  assign target = (bit_q == 4'd0) ? HalfM1 : DivM1;

  // Synchronise the line, find the start edge, sample every bit centre
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      busy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (!go_i) drdy_q <= 1'b0;
      if (!busy_q) begin
        if (prev_q && !s2_q) begin
          busy_q <= 1'b1;
          bit_q  <= '0;
          cnt_q  <= '0;
        end
      end else if (cnt_q == target) begin
        cnt_q <= '0;
        if (bit_q == 4'd0) begin
          if (s2_q) busy_q <= 1'b0;
          else      bit_q  <= 4'd1;
        end else if (bit_q <= 4'd8) begin
          shreg_q <= {s2_q, shreg_q[7:1]};
          bit_q   <= bit_q + 4'd1;
        end else begin
          busy_q <= 1'b0;
          if (s2_q) begin
            data_q <= shreg_q;
            drdy_q <= 1'b1;
          end
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uarttx.sv
// 8N1 serial transmitter started by a rising edge on go_i.
// Latency: start bit appears one cycle after go_i rises; bsy_o drops after the full stop bit.
// Backpressure: go_i edges while bsy_o=1 are ignored.
module uarttx #(
  parameter int ClockFrequencyHz = 20_250_000,
  parameter int BaudRate         = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       go_i,
  output logic       bsy_o,
  output logic       tx_o
);

  localparam int Div = ClockFrequencyHz / BaudRate;
  localparam int CW  = $clog2(Div) + 1;
  localparam logic [CW-1:0] DivM1 = CW'(Div - 1);

  logic          go_prev_q, bsy_q, tx_q;
  logic [9:0]    frame_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;

  assign bsy_o = bsy_q;
  assign tx_o  = tx_q;

  // Shift out {stop, data, start} one bit per baud period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_prev_q <= 1'b0;
      bsy_q     <= 1'b0;
      tx_q      <= 1'b1;
      frame_q   <= '1;
      bit_q     <= '0;
      cnt_q     <= '0;
    end else begin
      go_prev_q <= go_i;
      if (!bsy_q) begin
        if (go_i && !go_prev_q) begin
          bsy_q   <= 1'b1;
          frame_q <= {1'b1, data_i, 1'b0};
          bit_q   <= '0;
          cnt_q   <= '0;
          tx_q    <= 1'b0;
        end
      end else if (cnt_q == DivM1) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          bsy_q <= 1'b0;
          tx_q  <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          tx_q  <= frame_q[bit_q + 4'd1];
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ramio_uart_fifo.sv
// Memory-mapped UART with RX/TX byte FIFOs, status register and sticky overrun.
// Latency: reads are combinational; pushes/pops/clears take effect at the next edge.
// Backpressure: busy=1 on a TX push while the TX FIFO is full; RX bytes arriving at a full FIFO set overrun.
module ramio_uart_fifo
  import ramio_uart_fifo_pkg::*;
#(
  parameter int AddressBitWidth  = 32,
  parameter int DataBitWidth     = 32,
  parameter int ClockFrequencyHz = 20_250_000,
  parameter int BaudRate         = 9600,
  parameter int RxDepthLog2      = 4,
  parameter int TxDepthLog2      = 4,
  parameter logic [AddressBitWidth-1:0] AddressUartOut    = AddressBitWidth'(DefAddrUartOut),
  parameter logic [AddressBitWidth-1:0] AddressUartIn     = AddressBitWidth'(DefAddrUartIn),
  parameter logic [AddressBitWidth-1:0] AddressUartStatus = AddressBitWidth'(DefAddrUartStatus)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [2:0]                 read_type,
  input  logic [1:0]                 write_type,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [DataBitWidth-1:0]    data_in,
  output logic [DataBitWidth-1:0]    data_out,
  output logic                       data_out_ready,
  output logic                       busy,
  output logic                       hit,
  output logic                       uart_tx,
  input  logic                       uart_rx
);

  localparam int DW = DataBitWidth;

  // Address decode
  logic sel_out, sel_in, sel_stat, rd, wr;
  assign sel_out        = (address == AddressUartOut);
  assign sel_in         = (address == AddressUartIn);
  assign sel_stat       = (address == AddressUartStatus);
  assign hit            = sel_out || sel_in || sel_stat;
  assign data_out_ready = hit;
  assign rd             = enable && (read_type != 3'b000);
  assign wr             = enable && (write_type != 2'b00);

  // Only the low byte of write data is ever stored
  logic unused_data_in;
  assign unused_data_in = ^data_in[DW-1:8];

  // TX FIFO and push side
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]           tx_head;
  logic [TxDepthLog2:0] tx_count;
  assign tx_push = wr && sel_out && !tx_full;
  assign busy    = wr && sel_out && tx_full;

  io_fifo #(.Width(8), .DepthLog2(TxDepthLog2)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (data_in[7:0]),
    .data_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // TX FSM registers and transmitter
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_go_q, tx_go_d, tx_bsy, tx_idle_all;
  assign tx_idle_all = tx_empty && (tx_state_q == TX_IDLE);

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_byte_q  <= '0;
      tx_go_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      tx_go_q    <= tx_go_d;
    end
  end

  // TX FSM: pop head, hold go for the arming cycle, wait for the transmitter to finish
  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    tx_go_d    = tx_go_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          tx_go_d    = 1'b1;
          tx_state_d = TX_ARM;
        end
      end
      TX_ARM:  tx_state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_bsy) begin
          tx_go_d    = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  uarttx #(.ClockFrequencyHz(ClockFrequencyHz), .BaudRate(BaudRate)) u_uarttx (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (tx_byte_q),
    .go_i   (tx_go_q),
    .bsy_o  (tx_bsy),
    .tx_o   (uart_tx)
  );

  // RX side: receiver, capture handshake, FIFO
  logic                 rx_drdy, rx_go_q, rx_go_d, rx_cap, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]           rx_byte, rx_head;
  logic [RxDepthLog2:0] rx_count;
  logic                 overrun_q, overrun_d, stat_rd;

  assign rx_cap  = rx_drdy && rx_go_q;
  assign rx_pop  = rd && sel_in && !rx_empty;
  assign rx_push = rx_cap && (!rx_full || rx_pop);
  assign stat_rd = rd && sel_stat;

  uartrx #(.ClockFrequencyHz(ClockFrequencyHz), .BaudRate(BaudRate)) u_uartrx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (uart_rx),
    .go_i   (rx_go_q),
    .data_o (rx_byte),
    .drdy_o (rx_drdy)
  );

  io_fifo #(.Width(8), .DepthLog2(RxDepthLog2)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_byte),
    .data_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // go drops for one cycle to acknowledge a capture; overrun set beats a status-read clear
  always_comb begin
    rx_go_d   = !rx_cap;
    overrun_d = overrun_q;
    if (stat_rd) overrun_d = 1'b0;
    if (rx_cap && rx_full && !rx_pop) overrun_d = 1'b1;
  end

  // RX handshake and sticky overrun registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_go_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      rx_go_q   <= rx_go_d;
      overrun_q <= overrun_d;
    end
  end

  // Read data mux; zero unless a read of one of our addresses is presented
  logic [DW-1:0] status_word;
  always_comb begin
    status_word = '0;
    status_word[StatRxNotEmpty] = !rx_empty;
    status_word[StatTxFull]     = tx_full;
    status_word[StatOverrun]    = overrun_q;
    status_word[StatTxIdle]     = tx_idle_all;
    status_word[StatRxCountLsb +: 8] = 8'(rx_count);
    status_word[StatTxCountLsb +: 8] = 8'(tx_count);
    data_out = '0;
    if (rd) begin
      if (sel_out) begin
        if (tx_idle_all) data_out = '1;
        else             data_out = DW'(tx_count) + DW'(tx_state_q != TX_IDLE);
      end else if (sel_in) begin
        if (rx_empty) data_out = '1;
        else          data_out = DW'(rx_head);
      end else if (sel_stat) begin
        data_out = status_word;
      end
    end
  end

endmodule

// File: tb/tb_ramio_uart_fifo.sv
module tb_ramio_uart_fifo;

  localparam int          BitCyc = 8;
  localparam logic [31:0] A_OUT  = 32'hffff_fff8;
  localparam logic [31:0] A_IN   = 32'hffff_fff4;
  localparam logic [31:0] A_STAT = 32'hffff_ffdc;
  localparam logic [31:0] NONE   = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  read_type = 3'b000;
  logic [1:0]  write_type = 2'b00;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_ready, busy, hit, uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int failures = 0;

  ramio_uart_fifo #(
    .AddressBitWidth(32), .DataBitWidth(32),
    .ClockFrequencyHz(1_000_000), .BaudRate(125_000),
    .RxDepthLog2(2), .TxDepthLog2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read_type(read_type),
    .write_type(write_type), .address(address), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .hit(hit), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  // Serial line monitor: decodes 8N1 frames, sampling near bit centres
  logic [7:0] tx_seen[$];
  int frame_err = 0;
  int fall_cnt = 0;
  always @(negedge uart_tx) fall_cnt++;
  initial begin
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge uart_tx);
      repeat (BitCyc / 2) @(negedge clk);
      st = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BitCyc) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BitCyc) @(negedge clk);
      sp = uart_tx;
      if (st !== 1'b0 || sp !== 1'b1) frame_err++;
      tx_seen.push_back(b);
    end
  end

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    enable = 1'b1; read_type = 3'b010; write_type = 2'b00; address = a;
    @(negedge clk); d = data_out;
    @(posedge clk); #1;
    enable = 1'b0; read_type = 3'b000; address = 32'h0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] v, output logic b);
    enable = 1'b1; read_type = 3'b000; write_type = 2'b11; address = a;
    data_in = {24'hABCDEF, v};
    @(negedge clk); b = busy;
    @(posedge clk); #1;
    enable = 1'b0; write_type = 2'b00; address = 32'h0; data_in = 32'h0;
  endtask

  task automatic send_rx(input logic [7:0] v);
    logic [9:0] fr;
    fr = {1'b1, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (BitCyc) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the monitor has decoded n frames, then compare against the model
  task automatic check_tx(input string nm, input logic [7:0] exp[$]);
    int t;
    t = 0;
    while (tx_seen.size() < exp.size() && t < 4000) begin
      @(posedge clk); t++;
    end
    #1;
    checks++;
    if (tx_seen.size() != exp.size()) begin
      failures++;
      $display("FAIL %s frame count got %0d want %0d", nm, tx_seen.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (tx_seen[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s byte%0d got %02h want %02h", nm, i, tx_seen[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || data_out !== 32'h0 || hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs tx=%b busy=%b dout=%h hit=%b want 1 0 0 0", uart_tx, busy, data_out, hit);
    end
    rst_n = 1'b1;
    idle(2);
    bus_rd(A_IN, d);
    checks++;
    if (d !== NONE) begin failures++; $display("FAIL reset_uartin got %h want %h", d, NONE); end
    bus_rd(A_OUT, d);
    checks++;
    if (d !== NONE) begin failures++; $display("FAIL reset_uartout got %h want %h", d, NONE); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL reset_status got %h want 00000008", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic b;
    logic [7:0] exp[$];
    tx_seen.delete();
    exp = '{8'h41, 8'h42, 8'h43};
    foreach (exp[i]) bus_wr(A_OUT, exp[i], b);
    bus_rd(A_OUT, d);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL abc_pending got %h want 3", d); end
    check_tx("abc", exp);
    idle(3 * BitCyc);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL abc_status_idle got %h want 00000008", d); end
  endtask

  task automatic test_tx_full;
    logic b;
    int t;
    logic [7:0] exp[$];
    tx_seen.delete();
    for (int i = 0; i < 6; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      bus_wr(A_OUT, exp[i], b);
      checks++;
      if (b !== (i == 5)) begin
        failures++;
        $display("FAIL txfull_busy push%0d got %b want %b", i, b, (i == 5));
      end
    end
    t = 0;
    b = 1'b1;
    while (b && t < 400) begin
      bus_wr(A_OUT, exp[5], b);
      t++;
    end
    checks++;
    if (b !== 1'b0) begin failures++; $display("FAIL txfull_retry busy still %b want 0", b); end
    check_tx("txfull", exp);
    idle(3 * BitCyc);
  endtask

  task automatic test_rx_overrun;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i));
    idle(2 * BitCyc);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_040D) begin failures++; $display("FAIL rx_ovr_status got %h want 0000040d", d); end
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_IN, d);
      checks++;
      if (d !== 32'h10 + 32'(i)) begin failures++; $display("FAIL rx_pop%0d got %h want %h", i, d, 32'h10 + 32'(i)); end
    end
    bus_rd(A_IN, d);
    checks++;
    if (d !== NONE) begin failures++; $display("FAIL rx_pop_empty got %h want %h", d, NONE); end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL rx_ovr_cleared got %h want 00000008", d); end
  endtask

  // Status reads on every cycle across an overflowing capture: set must win
  task automatic test_overrun_same_cycle;
    logic [31:0] d;
    logic [7:0] v[$];
    logic saw;
    for (int i = 0; i < 5; i++) v.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) send_rx(v[i]);
    idle(2 * BitCyc);
    bus_rd(A_STAT, d);
    saw = 1'b0;
    fork
      send_rx(v[4]);
      for (int i = 0; i < 12 * BitCyc; i++) begin
        bus_rd(A_STAT, d);
        if (d[2] === 1'b1) saw = 1'b1;
      end
    join
    checks++;
    if (saw !== 1'b1) begin failures++; $display("FAIL ovr_same_cycle saw %b want 1", saw); end
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_IN, d);
      checks++;
      if (d !== {24'h0, v[i]}) begin failures++; $display("FAIL ovr_pop%0d got %h want %h", i, d, {24'h0, v[i]}); end
    end
  endtask

  task automatic test_random_rx;
    logic [31:0] d;
    logic b;
    logic [7:0] q[$];
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        send_rx(q[$]);
        idle($urandom_range(0, 5));
      end
      idle(2 * BitCyc);
      enable = 1'b1; read_type = 3'b000; address = A_IN;
      @(negedge clk);
      checks++;
      if (data_out !== 32'h0) begin failures++; $display("FAIL noread_dout got %h want 0", data_out); end
      @(posedge clk); #1;
      enable = 1'b0; address = 32'h0;
      bus_wr(A_IN, 8'h5A, b);
      while (q.size() > 0) begin
        bus_rd(A_IN, d);
        checks++;
        if (d !== {24'h0, q[0]}) begin failures++; $display("FAIL rand_rx got %h want %h", d, {24'h0, q[0]}); end
        void'(q.pop_front());
      end
      bus_rd(A_IN, d);
      checks++;
      if (d !== NONE) begin failures++; $display("FAIL rand_rx_empty got %h want %h", d, NONE); end
    end
  endtask

  task automatic test_random_tx;
    logic b;
    logic [7:0] exp[$];
    int n;
    for (int r = 0; r < 3; r++) begin
      tx_seen.delete();
      exp.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        exp.push_back(8'($urandom));
        bus_wr(A_OUT, exp[$], b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("FAIL rand_tx_busy got %b want 0", b); end
        idle($urandom_range(0, 3));
      end
      check_tx("rand_tx", exp);
      idle(3 * BitCyc);
    end
    checks++;
    if (frame_err !== 0) begin failures++; $display("FAIL framing errors got %0d want 0", frame_err); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] d;
    logic b;
    int t, base;
    for (int i = 0; i < 3; i++) bus_wr(A_OUT, 8'h00 + 8'(i), b);
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin @(posedge clk); t++; end
    idle(20);
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL abort_tx_line got %b want 1", uart_tx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    bus_rd(A_OUT, d);
    checks++;
    if (d !== NONE) begin failures++; $display("FAIL abort_uartout got %h want %h", d, NONE); end
    base = fall_cnt;
    idle(40 * BitCyc);
    checks++;
    if (fall_cnt !== base) begin failures++; $display("FAIL abort_quiet edges got %0d want 0", fall_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_tx_full();
    test_rx_overrun();
    test_overrun_same_cycle();
    test_random_rx();
    test_random_tx();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
